// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one sprite from frame ROM into the framebuffer, skipping colour-keyed and off-screen pixels
module sprite_blitter #(
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          FB_W        = 640,
    parameter int          FB_H        = 480,
    parameter logic [23:0] TRANSPARENT = 24'hFFFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    output logic        busy,
    output logic        done,
    output logic [18:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic [18:0] fb_addr,
    output logic [23:0] fb_data,
    output logic        fb_we,
    input  logic        fb_ready
);
    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;
    state_t        state_q, state_d;
    logic [9:0]    px_q, px_d, py_q, py_d;
    logic [XW-1:0] sx_q, sx_d;
    logic [YW-1:0] sy_q, sy_d;
    logic [18:0]   rom_addr_q, rom_addr_d, fb_addr_q, fb_addr_d;
    logic [23:0]   fb_data_q, fb_data_d;
    logic [10:0]   tx, ty;
    logic          last, need, adv, row_end;
    always_comb begin
        tx      = {1'b0, px_q} + 11'(sx_q);
        ty      = {1'b0, py_q} + 11'(sy_q);
        row_end = sx_q == XW'(SPR_W - 1);
        last    = row_end && sy_q == YW'(SPR_H - 1);
        need    = rom_data != TRANSPARENT && tx < 11'(FB_W) && ty < 11'(FB_H);
        adv     = (state_q == WAIT && !need) || (state_q == WRITE && fb_ready);
        state_d    = state_q;
        px_d       = px_q;
        py_d       = py_q;
        sx_d       = adv ? (row_end ? '0 : sx_q + XW'(1)) : sx_q;
        sy_d       = adv && row_end ? sy_q + YW'(1) : sy_q;
        rom_addr_d = adv && !last ? rom_addr_q + 19'd1 : rom_addr_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = FETCH;
                px_d       = pos_x;
                py_d       = pos_y;
                sx_d       = '0;
                sy_d       = '0;
                rom_addr_d = '0;
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                fb_data_d = rom_data;
                if (need) begin
                    state_d   = WRITE;
                    fb_addr_d = 19'(ty) * 19'(FB_W) + 19'(tx);
                end else begin
                    state_d = last ? DONE : FETCH;
                end
            end
            WRITE: if (fb_ready) state_d = last ? DONE : FETCH;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            px_q       <= '0;
            py_q       <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            rom_addr_q <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            py_q       <= py_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            rom_addr_q <= rom_addr_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end
    assign busy     = state_q == FETCH || state_q == WAIT || state_q == WRITE;
    assign done     = state_q == DONE;
    assign fb_we    = state_q == WRITE;
    assign rom_addr = rom_addr_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: scoreboard bench; expected framebuffer writes are queued per blit and popped by a write monitor
module tb_sprite_blitter;
    logic        Clk = 0, Reset = 1, start = 0, fb_ready = 1;
    logic [9:0]  pos_x = 0, pos_y = 0;
    logic        busy, done, fb_we;
    logic [18:0] rom_addr, fb_addr;
    logic [23:0] rom_data = 0, fb_data;
    logic [23:0] rom [1024];
    logic [42:0] exp_q [$];
    int          total = 0, passes = 0, wr_count = 0, last_addr = 0;
    logic        prev_stall = 0;
    logic [18:0] prev_addr = 0;
    logic [23:0] prev_data = 0;

    sprite_blitter dut (
        .Clk(Clk), .Reset(Reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) rom_data <= rom[rom_addr[9:0]];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (Reset) begin
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check(fb_we && fb_addr == prev_addr && fb_data == prev_data, "stall_hold",
                      {fb_we, fb_addr, fb_data}, {1'b1, prev_addr, prev_data});
            prev_stall = fb_we && !fb_ready;
            prev_addr  = fb_addr;
            prev_data  = fb_data;
            if (fb_we && fb_ready) begin
                wr_count++;
                last_addr = int'(fb_addr);
                if (exp_q.size() == 0) check(0, "unexpected_write", {fb_addr, fb_data}, 0);
                else begin
                    logic [42:0] e;
                    e = exp_q.pop_front();
                    check({fb_addr, fb_data} == e, "fb_write", {fb_addr, fb_data}, e);
                end
            end
        end
    end

    task automatic push_model(input int px, input int py);
        for (int sy = 0; sy < 32; sy++)
            for (int sx = 0; sx < 32; sx++) begin
                logic [23:0] d;
                int tx, ty;
                d  = rom[sy * 32 + sx];
                tx = px + sx;
                ty = py + sy;
                if (d != 24'hFFFFFF && tx < 640 && ty < 480) exp_q.push_back({19'(ty * 640 + tx), d});
            end
    endtask

    task automatic run_blit(input int px, input int py, input int exp_wr, input int exp_last,
                            input int stall, input bit poke);
        int cyc, base, stall_left;
        bit chk_next, chk_done;
        push_model(px, py);
        base = wr_count;
        cyc = 0;
        stall_left = stall;
        chk_next = 0;
        chk_done = 0;
        pos_x = 10'(px);
        pos_y = 10'(py);
        start = 1;
        tick;
        start = 0;
        check(busy && rom_addr == 0, "start_fetch", {busy, rom_addr}, {1'b1, 19'd0});
        for (int n = 0; n < 5000 && !done; n++) begin
            if (busy) cyc++;
            if (chk_next) begin
                check(busy && !fb_we && rom_addr == 1, "next_fetch", {busy, fb_we, rom_addr}, {2'b10, 19'd1});
                chk_next = 0;
            end
            fb_ready = !(stall_left > 0 && fb_we);
            if (!fb_ready) stall_left--;
            else if (stall > 0 && fb_we && !chk_done) begin
                chk_next = 1;
                chk_done = 1;
            end
            if (poke) begin
                start = n == 50;
                pos_x = n == 50 ? 10'd5 : 10'(px);
                pos_y = n == 50 ? 10'd5 : 10'(py);
            end
            tick;
        end
        check(done && !busy, "done_seen", {done, busy}, 2'b10);
        check(cyc == 2048 + exp_wr + stall, "busy_cycles", cyc, 2048 + exp_wr + stall);
        start = poke;
        pos_x = 10'd5;
        pos_y = 10'd5;
        fb_ready = 1;
        tick;
        start = 0;
        check(!done && !busy, "done_pulse_1cyc", {done, busy}, 2'b00);
        tick;
        check(!busy && !fb_we, "idle_after_done", {busy, fb_we}, 2'b00);
        check(wr_count - base == exp_wr, "write_count", wr_count - base, exp_wr);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        if (exp_last >= 0) check(last_addr == exp_last, "last_addr", last_addr, exp_last);
    endtask

    initial begin
        int base;
        bit bad;
        for (int i = 0; i < 1024; i++) rom[i] = 24'h00FF00;
        repeat (3) tick;
        Reset = 0;
        tick;
        check(!busy, "rst_busy", busy, 0);
        check(!done, "rst_done", done, 0);
        check(!fb_we, "rst_fb_we", fb_we, 0);
        check(rom_addr == 0, "rst_rom_addr", rom_addr, 0);
        check(fb_addr == 0, "rst_fb_addr", fb_addr, 0);
        check(fb_data == 0, "rst_fb_data", fb_data, 0);
        run_blit(0, 0, 1024, 19871, 0, 0);
        run_blit(0, 0, 1024, 19871, 5, 0);
        run_blit(40, 30, 1024, 39111, 0, 1);
        run_blit(620, 470, 200, 307199, 0, 0);
        for (int i = 0; i < 1024; i++) rom[i] = 24'hFFFFFF;
        run_blit(100, 100, 0, -1, 0, 0);
        for (int i = 0; i < 1024; i++) rom[i] = 24'h00FF00;
        push_model(0, 0);
        base = wr_count;
        pos_x = 0;
        pos_y = 0;
        start = 1;
        tick;
        start = 0;
        for (int n = 0; n < 1000 && wr_count - base < 100; n++) tick;
        check(wr_count - base == 100, "writes_before_reset", wr_count - base, 100);
        Reset = 1;
        tick;
        check(!fb_we && !busy && !done, "reset_mid_blit", {fb_we, busy, done}, 3'b000);
        Reset = 0;
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            tick;
            if (fb_we || done || busy) bad = 1;
        end
        check(!bad, "quiet_after_reset", bad, 0);
        run_blit(0, 0, 1024, 19871, 0, 0);
        for (int i = 0; i < 1024; i++) rom[i] = i % 5 == 0 ? 24'hFFFFFF : {8'hA5, 6'd0, 10'(i)};
        run_blit(3, 7, 819, 24354, 0, 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
